// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write, issue and scoreboard signals of the multi-port register file
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      hazard;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic                issue_v;
    logic [AW-1:0]       issue_rd;
    logic [AW:0]         busy_cnt;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_v, issue_rd,
        input  rdata, hazard, busy_cnt
    );
    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_v, issue_rd,
        output rdata, hazard, busy_cnt
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-read / 2-write register file with optional bypass and busy scoreboard
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input logic         clk,
    input logic         reset,
    reg_file_mp_if.slave bus
);
    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy, busy_nxt;
    logic [AW:0]         cnt_nxt;
    logic [AW-1:0]       ra;
    logic                m0, m1;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      hazard;

    always_comb begin
        busy_nxt = busy;
        if (bus.we0) busy_nxt[bus.waddr0] = 1'b0;
        if (bus.we1) busy_nxt[bus.waddr1] = 1'b0;
        // a new producer replaces the completing one, so set overrides clear
        if (bus.issue_v) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy         <= '0;
            bus.busy_cnt <= '0;
        end else begin
            if (bus.we0 && bus.waddr0 != '0) regs[bus.waddr0] <= bus.wdata0;
            if (bus.we1 && bus.waddr1 != '0) regs[bus.waddr1] <= bus.wdata1;
            busy         <= busy_nxt;
            bus.busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rdata  = '0;
        hazard = '0;
        ra     = '0;
        m0     = 1'b0;
        m1     = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.raddr[k*AW +: AW];
            m0 = BYPASS != 0 && bus.we0 && bus.waddr0 == ra && ra != '0;
            m1 = BYPASS != 0 && bus.we1 && bus.waddr1 == ra && ra != '0;
            rdata[k*XLEN +: XLEN] = m1 ? bus.wdata1 : m0 ? bus.wdata0 : regs[ra];
            hazard[k] = busy[ra] && ra != '0 && !(m0 || m1);
        end
    end

    assign bus.rdata  = rdata;
    assign bus.hazard = hazard;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus random checks of bypass and non-bypass register files against an array model
module tb_reg_file_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) b1 ();
    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) b0 ();
    assign b0.raddr    = b1.raddr;
    assign b0.we0      = b1.we0;
    assign b0.waddr0   = b1.waddr0;
    assign b0.wdata0   = b1.wdata0;
    assign b0.we1      = b1.we1;
    assign b0.waddr1   = b1.waddr1;
    assign b0.wdata1   = b1.wdata1;
    assign b0.issue_v  = b1.issue_v;
    assign b0.issue_rd = b1.issue_rd;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

    logic [XLEN-1:0] mem [NREGS];
    bit              busy [NREGS];
    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit wmatch(input int a, input bit byp, output logic [XLEN-1:0] d);
        d = '0;
        if (!byp || a == 0) return 1'b0;
        if (b1.we1 && int'(b1.waddr1) == a) begin d = b1.wdata1; return 1'b1; end
        if (b1.we0 && int'(b1.waddr0) == a) begin d = b1.wdata0; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
        logic [XLEN-1:0] d;
        if (a == 0) return '0;
        return wmatch(a, byp, d) ? d : mem[a];
    endfunction

    function automatic bit exp_hz(input int a, input bit byp);
        logic [XLEN-1:0] d;
        return a != 0 && busy[a] && !wmatch(a, byp, d);
    endfunction

    function automatic int nbusy();
        int n = 0;
        foreach (busy[i]) n += int'(busy[i]);
        return n;
    endfunction

    task automatic compare();
        int a;
        #1;
        for (int k = 0; k < NRD; k++) begin
            a = int'(b1.raddr[k*AW +: AW]);
            check($sformatf("rdata%0d_byp x%0d", k, a), b1.rdata[k*XLEN +: XLEN], exp_rd(a, 1'b1));
            check($sformatf("rdata%0d_nobyp x%0d", k, a), b0.rdata[k*XLEN +: XLEN], exp_rd(a, 1'b0));
            check($sformatf("hazard%0d_byp x%0d", k, a), 32'(b1.hazard[k]), 32'(exp_hz(a, 1'b1)));
            check($sformatf("hazard%0d_nobyp x%0d", k, a), 32'(b0.hazard[k]), 32'(exp_hz(a, 1'b0)));
        end
        check("busy_cnt_byp", 32'(b1.busy_cnt), 32'(nbusy()));
        check("busy_cnt_nobyp", 32'(b0.busy_cnt), 32'(nbusy()));
    endtask

    task automatic update();
        if (!reset) begin
            foreach (mem[i]) begin mem[i] = '0; busy[i] = 1'b0; end
        end else begin
            if (b1.we0 && b1.waddr0 != 0) mem[b1.waddr0] = b1.wdata0;
            if (b1.we1 && b1.waddr1 != 0) mem[b1.waddr1] = b1.wdata1;
            if (b1.we0) busy[b1.waddr0] = 1'b0;
            if (b1.we1) busy[b1.waddr1] = 1'b0;
            if (b1.issue_v && b1.issue_rd != 0) busy[b1.issue_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        compare();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        b1.raddr = '0; b1.we0 = 1'b0; b1.waddr0 = '0; b1.wdata0 = '0;
        b1.we1 = 1'b0; b1.waddr1 = '0; b1.wdata1 = '0;
        b1.issue_v = 1'b0; b1.issue_rd = '0;
    endtask

    function automatic logic [AW-1:0] raddr_rand();
        return $urandom_range(0, 1) != 0 ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clk);
        update();
        #1;
        idle();
        b1.we0 = 1'b1; b1.waddr0 = 5'd5; b1.wdata0 = 32'hDEADBEEF;
        tick();
        idle(); b1.raddr = {5'd0, 5'd5};
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("reset x5", b1.rdata[31:0], 32'h0);
        check("reset busy_cnt", 32'(b1.busy_cnt), 32'h0);
        check("reset hazard", 32'(b1.hazard), 32'h0);
        tick();
        idle(); b1.we0 = 1'b1; b1.waddr0 = 5'd0; b1.wdata0 = 32'h1234;
        tick();
        idle();
        #1;
        check("x0 after write", b1.rdata[31:0], 32'h0);
        b1.we0 = 1'b1; b1.waddr0 = 5'd7; b1.wdata0 = 32'hA5A5A5A5;
        tick();
        idle(); b1.raddr = {5'd7, 5'd7};
        #1;
        check("x7 port0", b1.rdata[31:0], 32'hA5A5A5A5);
        check("x7 port1", b1.rdata[63:32], 32'hA5A5A5A5);
        tick();
        idle(); b1.raddr = {5'd0, 5'd3};
        b1.we0 = 1'b1; b1.waddr0 = 5'd3; b1.wdata0 = 32'h11;
        b1.we1 = 1'b1; b1.waddr1 = 5'd3; b1.wdata1 = 32'h22;
        #1;
        check("bypass prio byp", b1.rdata[31:0], 32'h22);
        check("bypass prio nobyp", b0.rdata[31:0], 32'h0);
        tick();
        idle(); b1.raddr = {5'd0, 5'd3};
        #1;
        check("x3 after dual write byp", b1.rdata[31:0], 32'h22);
        check("x3 after dual write nobyp", b0.rdata[31:0], 32'h22);
        tick();
        idle(); b1.issue_v = 1'b1; b1.issue_rd = 5'd9;
        tick();
        idle(); b1.raddr = {5'd9, 5'd0};
        #1;
        check("issue x9 busy_cnt", 32'(b1.busy_cnt), 32'd1);
        check("issue x9 hazard1", 32'(b1.hazard[1]), 32'd1);
        tick();
        b1.we1 = 1'b1; b1.waddr1 = 5'd9; b1.wdata1 = 32'h55;
        #1;
        check("x9 bypass hazard1 byp", 32'(b1.hazard[1]), 32'd0);
        check("x9 bypass hazard1 nobyp", 32'(b0.hazard[1]), 32'd1);
        check("x9 bypass rdata1", b1.rdata[63:32], 32'h55);
        tick();
        idle();
        #1;
        check("x9 retired busy_cnt", 32'(b1.busy_cnt), 32'd0);
        tick();
        b1.issue_v = 1'b1; b1.issue_rd = 5'd4;
        tick();
        b1.we0 = 1'b1; b1.waddr0 = 5'd4; b1.wdata0 = 32'h77;
        tick();
        idle(); b1.raddr = {5'd0, 5'd4};
        #1;
        check("collision busy_cnt", 32'(b1.busy_cnt), 32'd1);
        check("collision hazard0", 32'(b1.hazard[0]), 32'd1);
        check("collision data", b1.rdata[31:0], 32'h77);
        tick();
        idle(); b1.we0 = 1'b1; b1.waddr0 = 5'd4; b1.wdata0 = 32'h78;
        tick();
        foreach (mem[i]) if (i == 2 || i == 6 || i == 8) begin
            idle(); b1.issue_v = 1'b1; b1.issue_rd = AW'(i);
            tick();
        end
        idle();
        #1;
        check("three busy", 32'(b1.busy_cnt), 32'd3);
        reset = 1'b0; b1.issue_v = 1'b1; b1.issue_rd = 5'd10;
        tick();
        idle();
        #1;
        check("midflight reset busy_cnt", 32'(b1.busy_cnt), 32'd0);
        foreach (mem[i]) if (i == 2 || i == 6 || i == 8 || i == 10) begin
            b1.raddr = {5'd0, AW'(i)};
            #1;
            check($sformatf("midflight reset hazard x%0d", i), 32'(b1.hazard[0]), 32'd0);
        end
        tick();
        for (int n = 0; n < 400; n++) begin
            reset       = $urandom_range(0, 39) != 0;
            b1.raddr    = {raddr_rand(), raddr_rand()};
            b1.we0      = 1'($urandom_range(0, 1));
            b1.waddr0   = raddr_rand();
            b1.wdata0   = $urandom;
            b1.we1      = 1'($urandom_range(0, 1));
            b1.waddr1   = $urandom_range(0, 3) == 0 ? b1.waddr0 : raddr_rand();
            b1.wdata1   = $urandom;
            b1.issue_v  = 1'($urandom_range(0, 1));
            b1.issue_rd = $urandom_range(0, 3) == 0 ? b1.waddr0 : raddr_rand();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
